bus_valve_drain: RTL and testbench

- Sequential successor to the plain combinational bus valve on OMNIBUS (Bus_if).
- On a close request it stops issuing new commands, tracks outstanding reads, and closes only once all responses have returned. Upstream masters therefore never lose a response that was already in flight.
- Sits between an upstream master segment and a downstream slave segment, e.g. for power-gating or isolating a slave subsystem.
- Parametrised outstanding depth, closed-state policy (stall or error-reply), and reset state.

---
 rtl/bus_valve_drain_if.sv | 30 +++
 rtl/bus_valve_drain.sv | 124 ++++++++++++
 tb/tb_bus_valve_drain.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_valve_drain_if.sv
// OMNIBUS command/response types and the Bus_if bundle shared by both sides of the valve.
package Bus;
   typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, RD = 2'd2} cmd_t;
   typedef enum logic [1:0] {NULL = 2'd0, DVA = 2'd1, ERR = 2'd2} resp_t;
endpackage

interface Bus_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
);
   Bus::cmd_t         MCmd;
   logic [AW-1:0]     MAddr;
   logic [DW-1:0]     MData;
   logic [DW/8-1:0]   MByteEn;
   logic              MRespAccept;
   logic              MReset_n;
   logic              SCmdAccept;
   Bus::resp_t        SResp;
   logic [DW-1:0]     SData;

   modport master (
      output MCmd, MAddr, MData, MByteEn, MRespAccept, MReset_n,
      input  SCmdAccept, SResp, SData
   );

   modport slave (
      input  MCmd, MAddr, MData, MByteEn, MRespAccept, MReset_n,
      output SCmdAccept, SResp, SData
   );
endinterface

// File: rtl/bus_valve_drain.sv
// Draining bus valve: on close it stops new commands, waits for in-flight reads to
// return, then isolates the downstream segment (stalling or error-replying upstream).
module bus_valve_drain #(
   parameter int unsigned MAX_OUTSTANDING = 8,
   parameter bit          DROP_MODE       = 1'b1,
   parameter bit          RESET_CLOSED    = 1'b0
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   Bus_if.slave                                 in,
   Bus_if.master                                out,
   input  logic                                 close,
   output logic                                 is_closed,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding
);
   localparam int unsigned   CW      = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {S_OPEN, S_DRAIN, S_CLOSED} state_t;
   localparam state_t S_RESET = RESET_CLOSED ? S_CLOSED : S_OPEN;

   state_t        r_state;
   state_t        w_nxt_state;
   logic [CW-1:0] r_cnt;
   logic          r_err_pend;
   logic          r_is_closed;
   logic          w_rd_full;
   logic          w_issue;
   logic          w_retire;
   logic          w_err_set;
   logic          w_err_clr;

   assign w_rd_full = (r_cnt == CNT_MAX);
   assign w_issue   = (out.MCmd == Bus::RD) && out.SCmdAccept;
   // Stray responses arriving while closed are not tracked reads.
   assign w_retire  = (r_state != S_CLOSED) && (out.SResp != Bus::NULL) && out.MRespAccept;
   assign w_err_set = DROP_MODE && (r_state == S_CLOSED) && (in.MCmd == Bus::RD) && in.SCmdAccept;
   assign w_err_clr = r_err_pend && in.MRespAccept;

   always_comb begin
      out.MCmd        = Bus::IDLE;
      out.MAddr       = in.MAddr;
      out.MData       = in.MData;
      out.MByteEn     = in.MByteEn;
      out.MRespAccept = in.MRespAccept;
      out.MReset_n    = in.MReset_n;
      in.SCmdAccept   = 1'b0;
      in.SResp        = out.SResp;
      in.SData        = out.SData;
      case (r_state)
         S_OPEN: begin
            if (!((in.MCmd == Bus::RD) && w_rd_full)) begin
               out.MCmd      = in.MCmd;
               in.SCmdAccept = out.SCmdAccept;
            end
         end
         S_CLOSED: begin
            out.MAddr       = 'x;
            out.MData       = 'x;
            out.MByteEn     = 'x;
            out.MRespAccept = 1'b1;
            out.MReset_n    = reset_n;
            in.SData        = '0;
            in.SResp        = Bus::NULL;
            if (DROP_MODE) begin
               in.SCmdAccept = !r_err_pend;
               if (r_err_pend) in.SResp = Bus::ERR;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      w_nxt_state = r_state;
      case (r_state)
         S_OPEN:
            if (close) w_nxt_state = S_DRAIN;
         S_DRAIN:
            if (!close)
               w_nxt_state = S_OPEN;
            else if ((r_cnt == '0) || ((r_cnt == CW'(1)) && w_retire))
               w_nxt_state = S_CLOSED;
         S_CLOSED:
            // A read accepted this cycle owes an ERR reply, so it also pins CLOSED.
            if (!close && !r_err_pend && !w_err_set) w_nxt_state = S_OPEN;
         default:
            w_nxt_state = S_RESET;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_RESET;
         r_is_closed <= RESET_CLOSED;
      end else begin
         r_state     <= w_nxt_state;
         r_is_closed <= (w_nxt_state == S_CLOSED);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt      <= '0;
         r_err_pend <= 1'b0;
      end else begin
         if (w_issue && !w_retire && (r_cnt != CNT_MAX))
            r_cnt <= r_cnt + 1'b1;
         else if (w_retire && !w_issue && (r_cnt != '0))
            r_cnt <= r_cnt - 1'b1;
         if (w_err_set)
            r_err_pend <= 1'b1;
         else if (w_err_clr)
            r_err_pend <= 1'b0;
      end
   end

   assign is_closed   = r_is_closed;
   assign outstanding = r_cnt;

   a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
      !(w_retire && !w_issue && (r_cnt == '0)));

endmodule

// File: tb/tb_bus_valve_drain.sv
// Directed bench: dut A = defaults (depth 8, error-reply, reset open);
// dut B = depth 2, stall when closed, reset closed.
module tb_bus_valve_drain;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a_n, rst_b_n, close_a, close_b, closed_a, closed_b;
   logic [3:0] cnt_a;
   logic [1:0] cnt_b;

   Bus_if a_in ();
   Bus_if a_out ();
   Bus_if b_in ();
   Bus_if b_out ();

   bus_valve_drain u_a (
      .clk(clk), .reset_n(rst_a_n), .in(a_in.slave), .out(a_out.master),
      .close(close_a), .is_closed(closed_a), .outstanding(cnt_a)
   );

   bus_valve_drain #(.MAX_OUTSTANDING(2), .DROP_MODE(1'b0), .RESET_CLOSED(1'b1)) u_b (
      .clk(clk), .reset_n(rst_b_n), .in(b_in.slave), .out(b_out.master),
      .close(close_b), .is_closed(closed_b), .outstanding(cnt_b)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic drv_a(input Bus::cmd_t cmd, input logic [31:0] addr, input logic sacc,
                        input Bus::resp_t sresp, input logic [31:0] sdata, input logic mra);
      a_in.MCmd = cmd;  a_in.MAddr = addr;  a_in.MRespAccept = mra;
      a_out.SCmdAccept = sacc;  a_out.SResp = sresp;  a_out.SData = sdata;
   endtask

   task automatic drv_b(input Bus::cmd_t cmd, input logic [31:0] addr, input logic sacc,
                        input Bus::resp_t sresp, input logic [31:0] sdata, input logic mra);
      b_in.MCmd = cmd;  b_in.MAddr = addr;  b_in.MRespAccept = mra;
      b_out.SCmdAccept = sacc;  b_out.SResp = sresp;  b_out.SData = sdata;
   endtask

   typedef struct {
      Bus::cmd_t   cmd;
      logic [31:0] addr;
      logic        sacc;
      Bus::resp_t  sresp;
      logic [31:0] sdata;
      logic        mra;
      Bus::cmd_t   e_cmd;
      logic        e_sacc;
      Bus::resp_t  e_sresp;
      logic [31:0] e_sdata;
      logic [3:0]  e_cnt;
   } vec_t;

   localparam int NV = 10;
   vec_t tv [NV];

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      tv[0] = '{Bus::IDLE, 32'h00, 1'b1, Bus::NULL, 32'h0,    1'b1, Bus::IDLE, 1'b1, Bus::NULL, 32'h0,    4'd0};
      tv[1] = '{Bus::RD,   32'h10, 1'b1, Bus::NULL, 32'h0,    1'b1, Bus::RD,   1'b1, Bus::NULL, 32'h0,    4'd0};
      tv[2] = '{Bus::IDLE, 32'h00, 1'b1, Bus::DVA,  32'hCAFE, 1'b1, Bus::IDLE, 1'b1, Bus::DVA,  32'hCAFE, 4'd1};
      tv[3] = '{Bus::WR,   32'h20, 1'b1, Bus::NULL, 32'h0,    1'b1, Bus::WR,   1'b1, Bus::NULL, 32'h0,    4'd0};
      tv[4] = '{Bus::RD,   32'h30, 1'b0, Bus::NULL, 32'h0,    1'b1, Bus::RD,   1'b0, Bus::NULL, 32'h0,    4'd0};
      tv[5] = '{Bus::RD,   32'h30, 1'b1, Bus::NULL, 32'h0,    1'b1, Bus::RD,   1'b1, Bus::NULL, 32'h0,    4'd0};
      tv[6] = '{Bus::RD,   32'h34, 1'b1, Bus::DVA,  32'hBEEF, 1'b1, Bus::RD,   1'b1, Bus::DVA,  32'hBEEF, 4'd1};
      tv[7] = '{Bus::IDLE, 32'h00, 1'b1, Bus::DVA,  32'h5555, 1'b0, Bus::IDLE, 1'b1, Bus::DVA,  32'h5555, 4'd1};
      tv[8] = '{Bus::IDLE, 32'h00, 1'b1, Bus::DVA,  32'h5555, 1'b1, Bus::IDLE, 1'b1, Bus::DVA,  32'h5555, 4'd1};
      tv[9] = '{Bus::IDLE, 32'h00, 1'b1, Bus::NULL, 32'h0,    1'b1, Bus::IDLE, 1'b1, Bus::NULL, 32'h0,    4'd0};

      rst_a_n = 1'b0;  rst_b_n = 1'b0;  close_a = 1'b0;  close_b = 1'b1;
      a_in.MData = 32'h1234;  a_in.MByteEn = 4'hF;  a_in.MReset_n = 1'b1;
      b_in.MData = 32'h5678;  b_in.MByteEn = 4'hF;  b_in.MReset_n = 1'b1;
      drv_a(Bus::IDLE, 32'h0, 1'b1, Bus::NULL, 32'h0, 1'b0);
      drv_b(Bus::IDLE, 32'h0, 1'b1, Bus::NULL, 32'h0, 1'b0);
      next();
      next();
      rst_a_n = 1'b1;  rst_b_n = 1'b1;

      @(negedge clk);
      chk("rst_a_closed", closed_a, 0);
      chk("rst_a_cnt", cnt_a, 0);
      chk("rst_b_closed", closed_b, 1);
      chk("rst_b_cnt", cnt_b, 0);
      next();

      // OPEN pass-through vectors on dut A
      for (int i = 0; i < NV; i++) begin
         drv_a(tv[i].cmd, tv[i].addr, tv[i].sacc, tv[i].sresp, tv[i].sdata, tv[i].mra);
         @(negedge clk);
         chk($sformatf("v%0d_mcmd", i), a_out.MCmd, tv[i].e_cmd);
         chk($sformatf("v%0d_maddr", i), a_out.MAddr, tv[i].addr);
         chk($sformatf("v%0d_scmdacc", i), a_in.SCmdAccept, tv[i].e_sacc);
         chk($sformatf("v%0d_sresp", i), a_in.SResp, tv[i].e_sresp);
         chk($sformatf("v%0d_sdata", i), a_in.SData, tv[i].e_sdata);
         chk($sformatf("v%0d_mra", i), a_out.MRespAccept, tv[i].mra);
         chk($sformatf("v%0d_cnt", i), cnt_a, tv[i].e_cnt);
         next();
      end

      // Three reads in flight, then close: drain and close after the last response
      for (int k = 0; k < 3; k++) begin
         drv_a(Bus::RD, 32'h40 + 32'(4 * k), 1'b1, Bus::NULL, 32'h0, 1'b1);
         @(negedge clk);
         chk($sformatf("d_issue%0d_cmd", k), a_out.MCmd, Bus::RD);
         chk($sformatf("d_issue%0d_cnt", k), cnt_a, 32'(k));
         next();
      end
      drv_a(Bus::IDLE, 32'h0, 1'b1, Bus::NULL, 32'h0, 1'b1);
      close_a = 1'b1;
      @(negedge clk);
      chk("d_cnt3", cnt_a, 3);
      next();
      drv_a(Bus::RD, 32'h50, 1'b1, Bus::NULL, 32'h0, 1'b1);
      @(negedge clk);
      chk("d_block_acc", a_in.SCmdAccept, 0);
      chk("d_block_cmd", a_out.MCmd, Bus::IDLE);
      chk("d_block_closed", closed_a, 0);
      next();
      for (int k = 0; k < 3; k++) begin
         drv_a(Bus::RD, 32'h50, 1'b1, Bus::DVA, 32'hA0 + 32'(k), 1'b1);
         @(negedge clk);
         chk($sformatf("d_resp%0d_sresp", k), a_in.SResp, Bus::DVA);
         chk($sformatf("d_resp%0d_sdata", k), a_in.SData, 32'hA0 + 32'(k));
         chk($sformatf("d_resp%0d_acc", k), a_in.SCmdAccept, 0);
         chk($sformatf("d_resp%0d_cnt", k), cnt_a, 32'(3 - k));
         chk($sformatf("d_resp%0d_closed", k), closed_a, 0);
         next();
      end
      drv_a(Bus::IDLE, 32'h0, 1'b1, Bus::NULL, 32'h0, 1'b0);
      @(negedge clk);
      chk("c_closed", closed_a, 1);
      chk("c_cnt", cnt_a, 0);
      chk("c_mra_forced", a_out.MRespAccept, 1);
      chk("c_mreset", a_out.MReset_n, 1);
      next();

      // Error-reply while closed; reopen deferred until ERR accepted
      drv_a(Bus::WR, 32'h60, 1'b1, Bus::NULL, 32'h0, 1'b0);
      @(negedge clk);
      chk("e_wr_acc", a_in.SCmdAccept, 1);
      chk("e_wr_cmd", a_out.MCmd, Bus::IDLE);
      chk("e_wr_sresp", a_in.SResp, Bus::NULL);
      next();
      drv_a(Bus::RD, 32'h64, 1'b1, Bus::NULL, 32'h0, 1'b0);
      @(negedge clk);
      chk("e_rd_acc", a_in.SCmdAccept, 1);
      chk("e_rd_sresp", a_in.SResp, Bus::NULL);
      next();
      drv_a(Bus::IDLE, 32'h0, 1'b1, Bus::DVA, 32'h77, 1'b0);
      close_a = 1'b0;
      @(negedge clk);
      chk("e_err1_sresp", a_in.SResp, Bus::ERR);
      chk("e_err1_sdata", a_in.SData, 0);
      chk("e_err1_acc", a_in.SCmdAccept, 0);
      chk("e_err1_closed", closed_a, 1);
      next();
      drv_a(Bus::IDLE, 32'h0, 1'b1, Bus::NULL, 32'h0, 1'b1);
      @(negedge clk);
      chk("e_err2_sresp", a_in.SResp, Bus::ERR);
      chk("e_err2_sdata", a_in.SData, 0);
      chk("e_err2_closed", closed_a, 1);
      next();
      drv_a(Bus::IDLE, 32'h0, 1'b1, Bus::NULL, 32'h0, 1'b0);
      @(negedge clk);
      chk("e_post_closed", closed_a, 1);
      chk("e_post_sresp", a_in.SResp, Bus::NULL);
      chk("e_post_acc", a_in.SCmdAccept, 1);
      next();
      drv_a(Bus::RD, 32'h70, 1'b0, Bus::NULL, 32'h0, 1'b1);
      @(negedge clk);
      chk("e_open_closed", closed_a, 0);
      chk("e_open_cmd", a_out.MCmd, Bus::RD);
      next();

      // Async reset while draining with two reads outstanding
      drv_a(Bus::RD, 32'h80, 1'b1, Bus::NULL, 32'h0, 1'b1);
      next();
      next();
      close_a = 1'b1;
      drv_a(Bus::IDLE, 32'h0, 1'b1, Bus::NULL, 32'h0, 1'b1);
      next();
      drv_a(Bus::RD, 32'h88, 1'b1, Bus::NULL, 32'h0, 1'b1);
      @(negedge clk);
      chk("r_drain_cnt", cnt_a, 2);
      chk("r_drain_cmd", a_out.MCmd, Bus::IDLE);
      #1 rst_a_n = 1'b0;
      #1;
      chk("r_a_cnt", cnt_a, 0);
      chk("r_a_closed", closed_a, 0);
      chk("r_a_cmd_open", a_out.MCmd, Bus::RD);
      close_a = 1'b0;
      drv_a(Bus::IDLE, 32'h0, 1'b1, Bus::NULL, 32'h0, 1'b0);
      next();
      rst_a_n = 1'b1;

      // Dut B: stall policy while closed, then reopen and pass the held write
      drv_b(Bus::WR, 32'h80, 1'b1, Bus::NULL, 32'h0, 1'b1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("s_hold%0d_acc", k), b_in.SCmdAccept, 0);
         chk($sformatf("s_hold%0d_cmd", k), b_out.MCmd, Bus::IDLE);
         chk($sformatf("s_hold%0d_sresp", k), b_in.SResp, Bus::NULL);
         next();
      end
      close_b = 1'b0;
      @(negedge clk);
      chk("s_rel_acc", b_in.SCmdAccept, 0);
      chk("s_rel_closed", closed_b, 1);
      next();
      @(negedge clk);
      chk("s_open_cmd", b_out.MCmd, Bus::WR);
      chk("s_open_addr", b_out.MAddr, 32'h80);
      chk("s_open_acc", b_in.SCmdAccept, 1);
      chk("s_open_closed", closed_b, 0);
      next();

      // Dut B: outstanding cap of 2
      drv_b(Bus::RD, 32'h90, 1'b1, Bus::NULL, 32'h0, 1'b1);
      @(negedge clk);
      chk("m1_acc", b_in.SCmdAccept, 1);
      chk("m1_cnt", cnt_b, 0);
      next();
      drv_b(Bus::RD, 32'h94, 1'b1, Bus::NULL, 32'h0, 1'b1);
      @(negedge clk);
      chk("m2_acc", b_in.SCmdAccept, 1);
      chk("m2_cnt", cnt_b, 1);
      next();
      drv_b(Bus::RD, 32'h98, 1'b1, Bus::NULL, 32'h0, 1'b1);
      @(negedge clk);
      chk("m3_acc", b_in.SCmdAccept, 0);
      chk("m3_cmd", b_out.MCmd, Bus::IDLE);
      chk("m3_cnt", cnt_b, 2);
      next();
      drv_b(Bus::WR, 32'h9C, 1'b1, Bus::NULL, 32'h0, 1'b1);
      @(negedge clk);
      chk("m4_wr_acc", b_in.SCmdAccept, 1);
      chk("m4_wr_cmd", b_out.MCmd, Bus::WR);
      chk("m4_cnt", cnt_b, 2);
      next();
      drv_b(Bus::RD, 32'h98, 1'b1, Bus::DVA, 32'h11, 1'b1);
      @(negedge clk);
      chk("m5_acc", b_in.SCmdAccept, 0);
      chk("m5_sresp", b_in.SResp, Bus::DVA);
      chk("m5_cnt", cnt_b, 2);
      next();
      drv_b(Bus::RD, 32'h98, 1'b1, Bus::NULL, 32'h0, 1'b1);
      @(negedge clk);
      chk("m6_acc", b_in.SCmdAccept, 1);
      chk("m6_cmd", b_out.MCmd, Bus::RD);
      chk("m6_cnt", cnt_b, 1);
      next();

      // Dut B: async reset while draining returns to CLOSED
      drv_b(Bus::IDLE, 32'h0, 1'b1, Bus::NULL, 32'h0, 1'b1);
      close_b = 1'b1;
      @(negedge clk);
      chk("rb_cnt2", cnt_b, 2);
      next();
      drv_b(Bus::RD, 32'hA0, 1'b1, Bus::NULL, 32'h0, 1'b1);
      @(negedge clk);
      chk("rb_drain_cmd", b_out.MCmd, Bus::IDLE);
      chk("rb_drain_closed", closed_b, 0);
      #1 rst_b_n = 1'b0;
      #1;
      chk("rb_closed", closed_b, 1);
      chk("rb_cnt", cnt_b, 0);
      chk("rb_cmd", b_out.MCmd, Bus::IDLE);
      chk("rb_mreset", b_out.MReset_n, 0);
      chk("rb_acc", b_in.SCmdAccept, 0);
      next();
      rst_b_n = 1'b1;
      next();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
